// File: rtl/seq_divider.sv
// seq_divider: multi-cycle 32-bit restoring divider, signed or unsigned per request.
// The iteration produces one quotient bit per cycle over 32 cycles. A FIX cycle
// then applies the sign correction, and a one-cycle DONE pulse presents the result.
// Optional feature: define DIV_ZERO_EARLY_EN to short-circuit a zero divisor
// straight to DONE and flag it on div_by_zero.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | 32 restoring iterations, one quotient bit per cycle
// FIX   | sign correction, result registers written
// DONE  | done pulse for one cycle, results valid
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] b_abs;
  logic [31:0] dq;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] a_abs_in;
  logic [31:0] b_abs_in;
  logic [32:0] partial;
  logic [32:0] diff;
  logic        take;
  logic        early_zero;
`ifdef DIV_ZERO_EARLY_EN
  logic        dbz_q;
`endif

  // Operand magnitudes, only folded when the request is signed and negative
  always_comb begin
    a_abs_in = (sign && A[31]) ? (~A + 32'd1) : A;
    b_abs_in = (sign && B[31]) ? (~B + 32'd1) : B;
  end

  // One restoring step: shift in the next dividend bit and subtract if it fits
  always_comb begin
    partial = {rem, dq[31]};
    diff    = partial - {1'b0, b_abs};
    take    = (partial >= {1'b0, b_abs});
  end

  // Zero-divisor short cut is only present in the early-exit build
  always_comb begin
`ifdef DIV_ZERO_EARLY_EN
    early_zero = (B == 32'd0);
`else
    early_zero = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = early_zero ? DONE : CALC;
      CALC: if (cnt == 6'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE: begin
        done = 1'b1;
`ifdef DIV_ZERO_EARLY_EN
        div_by_zero = dbz_q;
`endif
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 6'd0;
      b_abs     <= 32'd0;
      dq        <= 32'd0;
      rem       <= 32'd0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
`ifdef DIV_ZERO_EARLY_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_abs <= b_abs_in;
            dq    <= a_abs_in;
            rem   <= 32'd0;
            cnt   <= 6'd0;
            // A zero divisor keeps the all-ones quotient unnegated, so a signed
            // x/0 yields -1 regardless of the dividend sign.
            q_neg <= sign & (A[31] ^ B[31]) & (B != 32'd0);
            r_neg <= sign & A[31];
`ifdef DIV_ZERO_EARLY_EN
            dbz_q <= (B == 32'd0);
            if (B == 32'd0) begin
              quotient  <= 32'hFFFF_FFFF;
              remainder <= A;
            end
`endif
          end
        end
        CALC: begin
          rem <= take ? diff[31:0] : partial[31:0];
          dq  <= {dq[30:0], take};
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          quotient  <= q_neg ? (~dq + 32'd1) : dq;
          remainder <= r_neg ? (~rem + 32'd1) : rem;
        end
        DONE: begin
`ifdef DIV_ZERO_EARLY_EN
          dbz_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an
// arithmetic reference model with an edge-counting timing model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

`ifdef DIV_ZERO_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .A(A), .B(B),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: truncating division, remainder follows the dividend
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Timing model: edges elapsed since acceptance decide what must be visible
  bit          m_run = 0;
  bit          m_early = 0;
  int          m_t = 0;
  int          m_lat = 0;
  logic [31:0] m_pq = 0, m_pr = 0;
  logic [31:0] exp_q = 0, exp_r = 0;
  bit          exp_busy = 0, exp_done = 0, exp_dbz = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_t = 0; exp_q = 0; exp_r = 0;
      exp_busy = 0; exp_done = 0; exp_dbz = 0;
    end else begin
      if (!m_run) begin
        if (start) begin
          ref_div(sign, A, B, m_pq, m_pr);
          m_early = EARLY && (B == 32'd0);
          m_lat = m_early ? 0 : 33;
          m_t = 0;
          m_run = 1;
        end
      end else begin
        m_t++;
      end
      if (m_run && m_t > m_lat) m_run = 0;
      exp_busy = m_run && (m_t < m_lat);
      exp_done = m_run && (m_t == m_lat);
      exp_dbz  = exp_done && m_early;
      if (exp_done) begin
        exp_q = m_pq;
        exp_r = m_pr;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
    chk("quotient", quotient, exp_q);
    chk("remainder", remainder, exp_r);
  end

  // Issue one request and pin its result and latency to literal expectations
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input bit edbz, input int elat);
    int n;
    chk("pre_busy", 32'(busy), 32'd0);
    sign = s; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; sign = 1'($urandom);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("lit_q", quotient, eq);
    chk("lit_r", remainder, er);
    chk("lit_dbz", 32'(div_by_zero), 32'(edbz));
    @(negedge clk);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    bit first;
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);

    run_op(1'b0, 32'h0000_03E4, 32'h0000_029D, 32'h0000_0001, 32'h0000_0147, 1'b0, 33);
    run_op(1'b1, 32'hFFFF_FF61, 32'h0000_0058, 32'hFFFF_FFFF, 32'hFFFF_FFB9, 1'b0, 33);
    run_op(1'b0, 32'hFFFF_FF61, 32'h0000_0058, 32'h02E8_BA2C, 32'h0000_0041, 1'b0, 33);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33);
    run_op(1'b0, 32'h0000_006F, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_006F, EARLY, EARLY ? 0 : 33);

    // start held high with operands changing every cycle: only E0 and E35 accepted
    sign = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
    dones = 0; first = 1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (i < 69) begin
        A = $urandom; B = $urandom | 32'd1; sign = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first) begin
          chk("b2b_q", quotient, 32'd14);
          chk("b2b_r", remainder, 32'd2);
          first = 0;
        end
      end
    end
    chk("b2b_dones", 32'(dones), 32'd2);

    // Reset in the middle of CALC discards the operation
    sign = 1'b0; A = 32'd12345; B = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 33);

    // Randomized requests with ignored start pulses sprinkled in while busy
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sign = 1'($urandom);
      A = $urandom;
      case ($urandom_range(0, 5))
        0: B = $urandom_range(1, 20);
        1: begin sign = 1'b1; A = 32'h8000_0000; B = 32'hFFFF_FFFF; end
        2: begin sign = 1'b0; B = 32'd0; end
        3: B = -$urandom_range(1, 300);
        default: B = $urandom;
      endcase
      if (B == 32'd0) sign = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        A = $urandom; B = $urandom | 32'd1; sign = 1'($urandom);
        start = (c < 30) && ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      n = 0;
      while ((busy || done) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rand_idle", 32'(busy | done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
